// File: rtl/div_sched.sv
// div_sched: round-robin scheduler that shares one external iterative divider
// among NREQ requesters, with divide-by-zero bypass, BUSY timeout and response hold.
module div_sched #(
    parameter int N    = 256,
    parameter int NREQ = 4,
    parameter int TMO  = N + 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*N-1:0]       req_divd,
    input  logic [NREQ*N-1:0]       req_dvsr,
    output logic                    div_rst_n,
    output logic [N-1:0]            div_divd,
    output logic [N-1:0]            div_dvsr,
    input  logic [N-1:0]            div_val,
    input  logic [N-1:0]            div_rem,
    input  logic                    div_rdy,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [N-1:0]            rsp_quo,
    output logic [N-1:0]            rsp_rem,
    output logic                    rsp_dbz,
    output logic                    rsp_tmo
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TMO + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESP} state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [IDW-1:0] ptr_reg;
    logic           alive_reg;
    logic [CW-1:0]  cnt_reg;
    logic           div_rst_n_reg;
    logic [N-1:0]   divd_reg;
    logic [N-1:0]   dvsr_reg;
    logic [IDW-1:0] id_reg;
    logic [N-1:0]   quo_reg;
    logic [N-1:0]   rem_reg;
    logic           dbz_reg;
    logic           tmo_reg;

    logic [N-1:0]    divd_arr [NREQ];
    logic [N-1:0]    dvsr_arr [NREQ];
    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] hi_req;
    logic [IDW-1:0]  grant_idx;
    logic            grant_en;
    logic            grant_dbz;
    logic            tmo_hit;

    // Unpack operands; hi_mask marks requesters strictly after the last grantee.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign divd_arr[gi]  = req_divd[gi*N +: N];
            assign dvsr_arr[gi]  = req_dvsr[gi*N +: N];
            assign hi_mask[gi]   = (IDW'(gi) > ptr_reg);
            assign req_ready[gi] = grant_en && (grant_idx == IDW'(gi));
        end
    endgenerate

    assign hi_req = req_valid & hi_mask;

    // Lowest requester above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        grant_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) grant_idx = IDW'(i);
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (hi_req[i]) grant_idx = IDW'(i);
        end
    end

    // alive_reg keeps grants off until the first clock edge after reset release.
    assign grant_en  = alive_reg && (state_reg == IDLE) && (|req_valid);
    assign grant_dbz = (dvsr_arr[grant_idx] == '0);
    assign tmo_hit   = (cnt_reg == CW'(TMO - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rsp_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_en) begin
                    state_next = grant_dbz ? RESP : LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = BUSY;
            end
            BUSY: begin
                if (div_rdy || tmo_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture at grant, result capture in BUSY, held through RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg       <= IDW'(NREQ - 1);
            alive_reg     <= 1'b0;
            cnt_reg       <= '0;
            div_rst_n_reg <= 1'b0;
            divd_reg      <= '0;
            dvsr_reg      <= '0;
            id_reg        <= '0;
            quo_reg       <= '0;
            rem_reg       <= '0;
            dbz_reg       <= 1'b0;
            tmo_reg       <= 1'b0;
        end else begin
            alive_reg     <= 1'b1;
            div_rst_n_reg <= (state_next != LAUNCH);
            case (state_reg)
                IDLE: begin
                    if (grant_en) begin
                        ptr_reg  <= grant_idx;
                        id_reg   <= grant_idx;
                        divd_reg <= divd_arr[grant_idx];
                        dvsr_reg <= dvsr_arr[grant_idx];
                        quo_reg  <= '0;
                        rem_reg  <= '0;
                        dbz_reg  <= grant_dbz;
                        tmo_reg  <= 1'b0;
                    end
                end
                LAUNCH: begin
                    cnt_reg <= '0;
                end
                BUSY: begin
                    if (div_rdy) begin
                        quo_reg <= div_val;
                        rem_reg <= div_rem;
                    end else if (tmo_hit) begin
                        tmo_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign div_rst_n = div_rst_n_reg;
    assign div_divd  = divd_reg;
    assign div_dvsr  = dvsr_reg;
    assign rsp_id    = id_reg;
    assign rsp_quo   = quo_reg;
    assign rsp_rem   = rem_reg;
    assign rsp_dbz   = dbz_reg;
    assign rsp_tmo   = tmo_reg;

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: divider stand-in, transaction-level scoreboard checked
// every cycle, plus directed scenarios with hand-computed results.
module tb_div_sched;
    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int TMO  = N + 16;
    localparam int IDW  = 2;
    localparam int LAT  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_divd;
    logic [NREQ*N-1:0] req_dvsr;
    logic              div_rst_n;
    logic [N-1:0]      div_divd;
    logic [N-1:0]      div_dvsr;
    logic [N-1:0]      div_val;
    logic [N-1:0]      div_rem;
    logic              div_rdy;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_quo;
    logic [N-1:0]      rsp_rem;
    logic              rsp_dbz;
    logic              rsp_tmo;

    always #5 clk = ~clk;

    div_sched #(.N(N), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_divd(req_divd), .req_dvsr(req_dvsr),
        .div_rst_n(div_rst_n), .div_divd(div_divd), .div_dvsr(div_dvsr),
        .div_val(div_val), .div_rem(div_rem), .div_rdy(div_rdy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quo(rsp_quo), .rsp_rem(rsp_rem), .rsp_dbz(rsp_dbz), .rsp_tmo(rsp_tmo)
    );

    // Divider stand-in: result LAT cycles after its reset strobe, or never when hung.
    logic div_hang;
    int   dcnt;
    always @(posedge clk or negedge div_rst_n) begin
        if (!div_rst_n) begin
            dcnt    <= 0;
            div_rdy <= 1'b0;
            div_val <= '0;
            div_rem <= '0;
        end else if (!div_hang && !div_rdy) begin
            if (dcnt == LAT - 1) begin
                div_rdy <= 1'b1;
                div_val <= (div_dvsr != 0) ? div_divd / div_dvsr : '1;
                div_rem <= (div_dvsr != 0) ? div_divd % div_dvsr : '1;
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Scoreboard state: at most one operation is ever outstanding.
    bit           in_flight;
    bit           launch_due;
    bit           prev_rst;
    bit           alive_m;
    int           ptr_m;
    int           exp_g;
    logic [NREQ-1:0] exp_ready;
    int           exp_id;
    logic [N-1:0] exp_divd, exp_dvsr, exp_quo, exp_rem;
    bit           exp_dbz, exp_tmo;
    int           grant_log[$];
    int           rstn_lows;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (last + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_op(input int i, input logic [N-1:0] dd, input logic [N-1:0] ds);
        req_divd[i*N +: N] = dd;
        req_dvsr[i*N +: N] = ds;
    endtask

    task automatic wait_grant(input int i, output int gc);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready[i] && k < 200) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("grant_%0d_seen", i), req_ready[i], 1);
        gc = cyc;
    endtask

    task automatic issue(input int i, output int gc);
        @(posedge clk);
        #1 req_valid[i] = 1'b1;
        wait_grant(i, gc);
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(output int vc);
        int k;
        k = 0;
        @(negedge clk);
        while (!rsp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rsp_valid_seen", rsp_valid, 1);
        vc = cyc;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int g, v, a;
        int order [6] = '{0, 1, 2, 3, 0, 1};
        rst = 1'b0; req_valid = '0; req_divd = '0; req_dvsr = '0;
        rsp_ready = 1'b1; div_hang = 1'b0; rstn_lows = 0;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    in_flight = 0; launch_due = 0; ptr_m = NREQ - 1; prev_rst = 0;
                end else begin
                    alive_m = prev_rst;
                    prev_rst = 1;
                    exp_g = -1;
                    if (alive_m && !in_flight) exp_g = rr_pick(ptr_m, req_valid);
                    exp_ready = '0;
                    if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
                    check("req_ready", req_ready, exp_ready);
                    if (req_ready != 0) grant_log.push_back(onehot_idx(req_ready));
                    if (alive_m) begin
                        check("div_rst_n", div_rst_n, launch_due ? 0 : 1);
                        if (!div_rst_n) rstn_lows++;
                    end
                    launch_due = 0;
                    if (!in_flight) begin
                        check("rsp_valid_idle", rsp_valid, 0);
                    end else begin
                        if (exp_dbz) begin
                            check("rsp_valid_dbz", rsp_valid, 1);
                        end else begin
                            check("div_divd", div_divd, exp_divd);
                            check("div_dvsr", div_dvsr, exp_dvsr);
                        end
                        if (rsp_valid) begin
                            check("rsp_id", rsp_id, exp_id);
                            check("rsp_quo", rsp_quo, exp_quo);
                            check("rsp_rem", rsp_rem, exp_rem);
                            check("rsp_dbz", rsp_dbz, exp_dbz);
                            check("rsp_tmo", rsp_tmo, exp_tmo);
                            if (rsp_ready) begin
                                $display("rsp id=%0d quo=%0d rem=%0d dbz=%0d tmo=%0d cycle=%0d",
                                         rsp_id, rsp_quo, rsp_rem, rsp_dbz, rsp_tmo, cyc);
                                in_flight = 0;
                            end
                        end
                    end
                    if (exp_g >= 0) begin
                        exp_divd = req_divd[exp_g*N +: N];
                        exp_dvsr = req_dvsr[exp_g*N +: N];
                        exp_id   = exp_g;
                        exp_dbz  = (exp_dvsr == 0);
                        exp_tmo  = !exp_dbz && div_hang;
                        if (exp_dbz || exp_tmo) begin
                            exp_quo = '0;
                            exp_rem = '0;
                        end else begin
                            exp_quo = exp_divd / exp_dvsr;
                            exp_rem = exp_divd % exp_dvsr;
                        end
                        launch_due = !exp_dbz;
                        ptr_m      = exp_g;
                        in_flight  = 1;
                    end
                end
            end
        join_none

        // Reset values while rst is held low.
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_div_rst_n", div_rst_n, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_quo", rsp_quo, 0);
        check("rst_rsp_rem", rsp_rem, 0);
        check("rst_rsp_dbz", rsp_dbz, 0);
        check("rst_rsp_tmo", rsp_tmo, 0);
        check("rst_div_divd", div_divd, 0);
        check("rst_div_dvsr", div_dvsr, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("div_rst_n_before_edge", div_rst_n, 0);
        @(negedge clk);
        check("div_rst_n_after_edge", div_rst_n, 1);

        // 100 / 7 from requester 0.
        rstn_lows = 0;
        set_op(0, 100, 7);
        issue(0, g);
        wait_rsp(v);
        check("t1_id", rsp_id, 0);
        check("t1_quo", rsp_quo, 14);
        check("t1_rem", rsp_rem, 2);
        check("t1_dbz", rsp_dbz, 0);
        check("t1_tmo", rsp_tmo, 0);
        check("t1_rstn_pulses", rstn_lows, 1);

        // Divide by zero from requester 2.
        rstn_lows = 0;
        set_op(2, 55, 0);
        issue(2, g);
        wait_rsp(v);
        check("t2_latency_le2", ((v - g) <= 2), 1);
        check("t2_id", rsp_id, 2);
        check("t2_dbz", rsp_dbz, 1);
        check("t2_quo", rsp_quo, 0);
        check("t2_rem", rsp_rem, 0);
        check("t2_tmo", rsp_tmo, 0);
        repeat (2) @(negedge clk);
        check("t2_rstn_pulses", rstn_lows, 0);

        // All requesters active after reset: strict rotation.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 1000 + 37 * i, 3 + i);
        grant_log.delete();
        req_valid = '1;
        for (int k = 0; k < 400 && grant_log.size() < 6; k++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (20) @(negedge clk);
        check("t3_grant_count", grant_log.size(), 6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
            check($sformatf("t3_grant_%0d", k), grant_log[k], order[k]);
        end

        // Consumer stalls 10 cycles while requester 1 waits.
        rsp_ready = 1'b0;
        set_op(0, 50, 6);
        set_op(1, 81, 9);
        grant_log.delete();
        @(posedge clk);
        #1 req_valid = 4'b0011;
        wait_grant(0, g);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_rsp(v);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t4_hold_valid", rsp_valid, 1);
            check("t4_hold_ready", req_ready, 0);
            check("t4_hold_id", rsp_id, 0);
            check("t4_hold_quo", rsp_quo, 8);
            check("t4_hold_rem", rsp_rem, 2);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        a = cyc;
        wait_grant(1, g);
        check("t4_grant_after_accept", g - a, 1);
        check("t4_first_grant", grant_log[0], 0);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        wait_rsp(v);
        check("t4_id", rsp_id, 1);
        check("t4_quo", rsp_quo, 9);
        check("t4_rem", rsp_rem, 0);

        // Hung divider: timeout exactly TMO cycles after BUSY entry.
        div_hang = 1'b1;
        set_op(3, 10, 3);
        issue(3, g);
        wait_rsp(v);
        check("t5_tmo_latency", v - (g + 2), TMO);
        check("t5_tmo", rsp_tmo, 1);
        check("t5_dbz", rsp_dbz, 0);
        check("t5_quo", rsp_quo, 0);
        check("t5_rem", rsp_rem, 0);
        check("t5_id", rsp_id, 3);
        div_hang = 1'b0;
        set_op(0, 1000, 10);
        issue(0, g);
        wait_rsp(v);
        check("t5b_id", rsp_id, 0);
        check("t5b_quo", rsp_quo, 100);
        check("t5b_rem", rsp_rem, 0);
        check("t5b_tmo", rsp_tmo, 0);

        // Reset while BUSY aborts the operation.
        div_hang = 1'b1;
        set_op(1, 77, 5);
        issue(1, g);
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_div_rst_n", div_rst_n, 0);
        check("t6_req_ready", req_ready, 0);
        check("t6_rsp_id", rsp_id, 0);
        check("t6_div_divd", div_divd, 0);
        check("t6_div_dvsr", div_dvsr, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        div_hang = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_no_rsp", rsp_valid, 0);
        issue(1, g);
        wait_rsp(v);
        check("t6b_id", rsp_id, 1);
        check("t6b_quo", rsp_quo, 15);
        check("t6b_rem", rsp_rem, 2);
        check("t6b_flags", {rsp_dbz, rsp_tmo}, 0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have parameter N, default 256, meaning operand/result width in bits.
REQ-002 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-003 SHALL have parameter TMO, default N+16, meaning BUSY timeout in cycles.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-007 SHALL have port req_ready  output  NREQ  one-hot grant/accept pulse.
REQ-008 SHALL have port req_divd  input  NREQ*N  dividends, requester i at bits [i*N +: N].
REQ-009 SHALL have port req_dvsr  input  NREQ*N  divisors, same packing.
REQ-010 SHALL have port div_rst_n  output  1  restart strobe to divider reset, active-low.
REQ-011 SHALL have port div_divd, div_dvsr  output  N each  operands held to divider.
REQ-012 SHALL have port div_val, div_rem  input  N each  divider quotient/remainder.
REQ-013 SHALL have port div_rdy  input  1  divider data-ready level.
REQ-014 SHALL have port rsp_valid  output  1  response available.
REQ-015 SHALL have port rsp_ready  input  1  response consumer accept.
REQ-016 SHALL have port rsp_id  output  $clog2(NREQ)  index of requester served.
REQ-017 SHALL have port rsp_quo, rsp_rem  output  N each  result.
REQ-018 SHALL have port rsp_dbz, rsp_tmo  output  1 each  divide-by-zero / timeout flags.

Function
REQ-019 SHALL implement FSM states IDLE, LAUNCH, BUSY, RESP.
REQ-020 IDLE: when any req_valid set, SHALL grant one requester g by round-robin, pulse req_ready[g] for exactly that cycle, and capture its operands and id.
REQ-021 Round-robin SHALL search starting at (last grantee + 1) mod NREQ; last-grantee pointer resets to NREQ-1 so requester 0 wins first.
REQ-022 Requester whose captured dvsr==0 SHALL go IDLE->RESP directly with rsp_dbz=1, quo=rem=0, and no div_rst_n pulse.
REQ-023 Otherwise IDLE->LAUNCH; LAUNCH drives div_rst_n low for exactly one cycle, then ->BUSY.
REQ-024 div_divd/div_dvsr SHALL be the captured operands, stable from LAUNCH through end of BUSY.
REQ-025 BUSY: on div_rdy=1 SHALL latch div_val/div_rem into rsp_quo/rsp_rem and ->RESP with flags 0.
REQ-026 BUSY: SHALL count cycles; if div_rdy not seen after TMO cycles, ->RESP with rsp_tmo=1, quo=rem=0.
REQ-027 RESP: rsp_valid=1 and all rsp_* outputs SHALL be stable until the cycle rsp_valid&&rsp_ready, then ->IDLE.
REQ-028 No grant SHALL occur outside IDLE; req_ready SHALL be 0 in LAUNCH, BUSY, RESP.
REQ-029 Minimum occupancy: one IDLE cycle between consecutive grants (no back-to-back grant in RESP exit cycle).
REQ-030 req_valid deasserted by a non-granted requester SHALL have no effect; granted request is never dropped.
REQ-031 div_rst_n SHALL be 1 in all states except LAUNCH.

Reset
REQ-032 On rst low, asynchronously: state=IDLE, req_ready=0, div_rst_n=0, rsp_valid=0, rsp_id=0, rsp_quo=rsp_rem=0, rsp_dbz=rsp_tmo=0, div_divd=div_dvsr=0, timeout counter=0, pointer=NREQ-1.
REQ-033 div_rst_n SHALL follow rst low asynchronously so divider is reset with controller; after rst release, div_rst_n=1 from first clock edge.
REQ-034 Reset mid-BUSY or mid-RESP SHALL abort the in-flight operation with no response issued.

Verification
REQ-035 Req 0 divd=100 dvsr=7 -> one div_rst_n pulse, rsp_id=0, rsp_quo=14, rsp_rem=2, flags 0.
REQ-036 Req 2 dvsr=0 -> rsp_valid within 2 cycles of grant, rsp_dbz=1, quo=rem=0, div_rst_n never low.
REQ-037 All 4 req_valid held high after reset, rsp_ready=1 -> grant order 0,1,2,3,0,1; each rsp_id matches.
REQ-038 rsp_ready low 10 cycles in RESP, req_valid[1] high -> rsp_* stable, req_ready stays 0, grant only after accept.
REQ-039 Divider model never raises div_rdy -> rsp_tmo=1 exactly TMO cycles after BUSY entry, then next request served normally.
REQ-040 rst low during BUSY -> all outputs at reset values immediately, no rsp_valid; new request after release completes correctly.
